// File: rtl/week6_pkg.sv
// Shared definitions for the week6 sequenced decoder.
//   state_e   : decoder FSM state
//   CODE_W    : width of the encoded index
//   ONEHOT_W  : width of the one-hot decode
//   max3      : helper used to size the pulse/gap timer
//   decode_onehot : 1 << code
package week6_pkg;

  localparam int unsigned CODE_W   = 2;
  localparam int unsigned ONEHOT_W = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StGap   = 2'd2
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic logic [ONEHOT_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
    return ONEHOT_W'(1) << code;
  endfunction

endpackage

// File: rtl/week6_sat_counter.sv
// Saturating event counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (an inc in the same cycle still counts once)
//   inc        : count one event
//   count      : current value, sticks at all-ones
module week6_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      // Clear wins over the old value, but a coincident event is not lost.
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/week6_ex1_decoder_seq.sv
// Sequenced 2-to-4 decoder with per-code saturating event counters.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : allows new accepts; a pulse in flight always completes
//   in_valid, in_ready, in_code : code handshake (in_ready registered)
//   out        : registered one-hot, held HOLD_CYCLES cycles per accept
//   busy       : pulse or trailing gap in progress
//   clr_cnt    : synchronous clear of all counters
//   evt_count  : counter for code i at [i*CNT_W +: CNT_W]
module week6_ex1_decoder_seq
  import week6_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CODE_W-1:0]         in_code,
  output logic [ONEHOT_W-1:0]       out,
  output logic                      busy,
  input  logic                      clr_cnt,
  output logic [ONEHOT_W*CNT_W-1:0] evt_count
);

  localparam int unsigned TW          = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, 2));
  localparam int unsigned GapLoadInt  = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
  localparam logic [TW-1:0] HoldLoad  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GapLoad   = TW'(GapLoadInt);
  localparam bit            HasGap    = (GAP_CYCLES != 0);

  state_e                state_q;
  logic [TW-1:0]         timer_q;
  logic                  accept;
  logic [ONEHOT_W-1:0]   inc;

  assign accept = in_valid && in_ready;
  assign busy   = (state_q != StIdle);
  assign inc    = accept ? decode_onehot(in_code) : '0;

  // in_ready is computed from the state being entered so it can never overlap busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      out      <= '0;
      in_ready <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q  <= StDrive;
            timer_q  <= HoldLoad;
            out      <= decode_onehot(in_code);
            in_ready <= 1'b0;
          end else begin
            in_ready <= en;
          end
        end
        StDrive: begin
          in_ready <= 1'b0;
          if (timer_q == '0) begin
            out <= '0;
            if (HasGap) begin
              state_q <= StGap;
              timer_q <= GapLoad;
            end else begin
              state_q  <= StIdle;
              timer_q  <= '0;
              in_ready <= en;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        StGap: begin
          if (timer_q == '0) begin
            state_q  <= StIdle;
            in_ready <= en;
          end else begin
            timer_q  <= timer_q - TW'(1);
            in_ready <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          timer_q  <= '0;
          out      <= '0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < ONEHOT_W; i++) begin : g_cnt
    week6_sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .inc   (inc[i]),
      .count (evt_count[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_week6_ex1_decoder_seq.sv
module tb_week6_ex1_decoder_seq;

  localparam int H    = 4;
  localparam int G    = 1;
  localparam int MAXC = 255;

  logic        clk, rst_n, en, in_valid, clr_cnt;
  logic [1:0]  in_code;
  logic        in_ready, busy;
  logic [3:0]  out;
  logic [31:0] evt_count;

  logic        en2, valid2, clr2;
  logic [1:0]  code2;
  logic        ready2, busy2;
  logic [3:0]  out2;
  logic [7:0]  evt2;

  week6_ex1_decoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out(out), .busy(busy), .clr_cnt(clr_cnt), .evt_count(evt_count)
  );

  week6_ex1_decoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .in_valid(valid2), .in_ready(ready2),
    .in_code(code2), .out(out2), .busy(busy2), .clr_cnt(clr2), .evt_count(evt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: time-based, in edges since the last accept.
  int   n;
  bit   have_acc;
  int   acc_edge;
  int   acc_code;
  bit   m_ready;
  bit   acc_last;
  int   cnt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_busy();
    if (!have_acc) return 1'b0;
    return (n - acc_edge) < (H + G);
  endfunction

  function automatic logic [3:0] m_out();
    logic [3:0] one;
    one = 4'b0001;
    if (!have_acc || (n - acc_edge) >= H) return 4'b0000;
    return one << acc_code;
  endfunction

  function automatic logic [31:0] m_evt();
    logic [31:0] e;
    for (int i = 0; i < 4; i++) e[i*8 +: 8] = cnt[i][7:0];
    return e;
  endfunction

  task automatic model_reset();
    have_acc = 1'b0;
    acc_edge = 0;
    acc_code = 0;
    m_ready  = 1'b0;
    acc_last = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  task automatic compare_all();
    chk("out", {28'd0, out}, {28'd0, m_out()});
    chk("busy", {31'd0, busy}, {31'd0, m_busy()});
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    chk("evt_count", evt_count, m_evt());
  endtask

  // One clock edge: model consumes the inputs present before the edge.
  task automatic step();
    bit a, e, c;
    int code;
    a    = in_valid && m_ready;
    code = int'(in_code);
    e    = en;
    c    = clr_cnt;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      n++;
      acc_last = a;
      if (a) begin
        have_acc = 1'b1;
        acc_edge = n;
        acc_code = code;
      end
      if (c) for (int i = 0; i < 4; i++) cnt[i] = 0;
      if (a && cnt[code] < MAXC) cnt[code]++;
      m_ready = e && !m_busy();
    end
    #1;
    compare_all();
  endtask

  task automatic wait_accept(output bit ok, output int at);
    bit a;
    ok = 1'b0;
    at = 0;
    for (int c = 0; c < 20; c++) begin
      a = in_valid && in_ready;
      step();
      if (a) begin
        ok = 1'b1;
        at = n;
        break;
      end
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  typedef struct packed {
    logic [1:0] code;
    logic [3:0] exp_out;
  } vec_t;

  vec_t tbl [4];

  initial begin
    bit ok;
    int at, prev, hi, acc_seen, rdy_seen, acc2;
    bit a;

    tbl[0] = '{code: 2'b00, exp_out: 4'b0001};
    tbl[1] = '{code: 2'b01, exp_out: 4'b0010};
    tbl[2] = '{code: 2'b10, exp_out: 4'b0100};
    tbl[3] = '{code: 2'b11, exp_out: 4'b1000};

    n = 0;
    model_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_code = 2'b00; clr_cnt = 1'b0;
    en2 = 1'b0; valid2 = 1'b0; code2 = 2'b00; clr2 = 1'b0;

    // Reset with en=1
    #3;
    compare_all();
    step();
    step();
    chk("ready_in_reset", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_release", {31'd0, in_ready}, 32'd1);
    chk("evt_after_reset", evt_count, 32'd0);

    // All four codes, valid held until accepted
    prev = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_code = tbl[i].code;
      wait_accept(ok, at);
      chk("onehot", {28'd0, out}, {28'd0, tbl[i].exp_out});
      if (i > 0) chk("accept_spacing", at - prev, 32'd6);
      prev = at;
      in_valid = 1'b0;
      hi = (out == tbl[i].exp_out) ? 1 : 0;
      for (int j = 0; j < 5; j++) begin
        step();
        if (out == tbl[i].exp_out) hi++;
      end
      chk("hold_len", hi, 32'd4);
      in_valid = 1'b1;
    end
    in_valid = 1'b0;
    chk("evt_four_codes", evt_count, 32'h01010101);

    // Valid held continuously with code 10
    in_valid = 1'b1;
    in_code  = 2'b10;
    for (int j = 0; j < 20; j++) begin
      step();
      chk("ready_and_busy", {31'd0, in_ready && busy}, 32'd0);
    end
    in_valid = 1'b0;
    for (int j = 0; j < 6; j++) step();

    // Drop en during a pulse
    in_valid = 1'b1;
    in_code  = 2'b10;
    wait_accept(ok, at);
    hi = (out == 4'b0100) ? 1 : 0;
    acc_seen = 0;
    rdy_seen = 0;
    for (int j = 0; j < 13; j++) begin
      if (j == 1) en = 1'b0;
      if (in_valid && in_ready) acc_seen++;
      step();
      if (out == 4'b0100) hi++;
      if (in_ready) rdy_seen++;
    end
    chk("en_low_pulse_len", hi, 32'd4);
    chk("en_low_no_accept", acc_seen, 32'd0);
    chk("en_low_no_ready", rdy_seen, 32'd0);
    en = 1'b1;
    wait_accept(ok, at);
    chk("en_back_onehot", {28'd0, out}, 32'h4);
    in_valid = 1'b0;

    // Reset two cycles into a pulse
    for (int j = 0; j < 6; j++) step();
    in_valid = 1'b1;
    in_code  = 2'b11;
    wait_accept(ok, at);
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_out", {28'd0, out}, 32'd0);
    chk("rst_evt", evt_count, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_code  = 2'b01;
    wait_accept(ok, at);
    chk("post_reset_onehot", {28'd0, out}, 32'h2);
    chk("post_reset_evt", evt_count, 32'h00000100);
    in_valid = 1'b0;

    // CNT_W=2 saturation and clear-with-accept
    en2 = 1'b1;
    valid2 = 1'b1;
    code2 = 2'b01;
    acc2 = 0;
    for (int c = 0; c < 80 && acc2 < 5; c++) begin
      a = valid2 && ready2;
      step();
      if (a) acc2++;
    end
    valid2 = 1'b0;
    chk("sat_accepts", acc2, 32'd5);
    chk("sat_evt", {24'd0, evt2}, 32'h0C);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (ready2) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("sat_ready_timeout", {31'd0, ok}, 32'd1);
    valid2 = 1'b1;
    clr2 = 1'b1;
    step();
    valid2 = 1'b0;
    clr2 = 1'b0;
    chk("clr_with_accept", {24'd0, evt2}, 32'h04);
    chk("clr_accept_out", {28'd0, out2}, 32'h2);
    en2 = 1'b0;

    // Randomized traffic against the model
    for (int j = 0; j < 400; j++) begin
      en       = ($urandom_range(0, 9) != 0);
      in_valid = $urandom_range(0, 1) != 0;
      in_code  = 2'($urandom_range(0, 3));
      clr_cnt  = ($urandom_range(0, 15) == 0);
      step();
    end
    clr_cnt  = 1'b0;
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
